// File: rtl/config_frame_loader_pkg.sv
// Shared definitions for the configuration frame loader.
//   - loaderState_e      : loader FSM states (IDLE, HEADER, DATA)
//   - DefaultSyncWord    : default start-of-bitstream marker
//   - DefaultDesyncWord  : default end-of-bitstream marker
//   - HdrCol*/HdrRsvd*   : header field positions (column [7:0], reserved [31:8])
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA
  } loaderState_e;

  localparam logic [31:0] DefaultSyncWord   = 32'hFAB0_FAB1;
  localparam logic [31:0] DefaultDesyncWord = 32'hFAB0_FAB0;

  localparam int HdrColLsb  = 0;
  localparam int HdrColMsb  = 7;
  localparam int HdrRsvdLsb = 8;
  localparam int HdrRsvdMsb = 31;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decoder that turns a (column, frame, enable) request
// into a single-cycle strobe on bit column*MaxFramesPerCol + frame.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   column_i  : column index of the frame to strobe
//   frame_i   : frame index within the column
//   enable_i  : request a strobe on the next edge
//   strobe_o  : one-hot strobe vector, MaxFramesPerCol*NumColumns bits
module frame_strobe_decoder #(
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 16,
  parameter int FrameCntW       = $clog2(MaxFramesPerCol)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [7:0]                            column_i,
  input  logic [FrameCntW-1:0]                  frame_i,
  input  logic                                  enable_i,
  output logic [MaxFramesPerCol*NumColumns-1:0] strobe_o
);

  localparam int NumStrobes = MaxFramesPerCol * NumColumns;
  localparam int IdxW       = $clog2(NumStrobes);

  logic [IdxW-1:0]       index;
  logic [NumStrobes-1:0] strobe_d;
  logic [NumStrobes-1:0] strobe_q;

  // Flat index of the addressed frame. The column has already been
  // range-checked by the loader, so the index always lands in the vector.
  always_comb begin
    index    = IdxW'(column_i) * IdxW'(MaxFramesPerCol) + IdxW'(frame_i);
    strobe_d = '0;
    for (int i = 0; i < NumStrobes; i++) begin
      strobe_d[i] = enable_i && (index == IdxW'(i));
    end
  end

  // Strobe register: with no request it falls back to all-zero, so every
  // strobe lasts exactly one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/config_frame_loader.sv
// Configuration frame loader: consumes a 32-bit word stream, waits for the
// sync word, decodes per-column headers and writes frame words into the
// fabric with a one-cycle strobe on the addressed frame.
// Ports:
//   CLK, RST      : clock (rising edge) and asynchronous active-high reset
//   WriteData     : incoming configuration word
//   WriteValid    : WriteData valid
//   WriteReady    : loader accepts a word (low during reset and one cycle after)
//   FrameData     : frame word, stable for the whole strobe cycle
//   FrameStrobe   : one-hot frame write strobe, bit = col*MaxFramesPerCol+frame
//   ConfigActive  : high between sync and desync
//   ConfigDone    : sticky, set by desync
//   ConfigError   : sticky, set by a bad header
module config_frame_loader
  import config_loader_pkg::*;
#(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumColumns      = 16,
  parameter logic [31:0] SyncWord        = DefaultSyncWord,
  parameter logic [31:0] DesyncWord      = DefaultDesyncWord
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [31:0]                           WriteData,
  input  logic                                  WriteValid,
  output logic                                  WriteReady,
  output logic [FrameBitsPerRow-1:0]            FrameData,
  output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe,
  output logic                                  ConfigActive,
  output logic                                  ConfigDone,
  output logic                                  ConfigError
);

  localparam int                   FrameCntW = $clog2(MaxFramesPerCol);
  localparam logic [FrameCntW-1:0] LastFrame = FrameCntW'(MaxFramesPerCol - 1);

  loaderState_e               state_q, state_d;
  logic [7:0]                 column_q, column_d;
  logic [FrameCntW-1:0]       frameCnt_q, frameCnt_d;
  logic                       ready_q;
  logic                       active_q, active_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic                       pendEn_q, pendEn_d;
  logic [7:0]                 pendCol_q, pendCol_d;
  logic [FrameCntW-1:0]       pendFrame_q, pendFrame_d;
  logic [FrameBitsPerRow-1:0] pendData_q, pendData_d;
  logic [FrameBitsPerRow-1:0] frameData_q;

  logic       accept;
  logic [7:0] hdrCol;
  logic       headerOk;

  assign accept   = WriteValid && ready_q;
  assign hdrCol   = WriteData[HdrColMsb:HdrColLsb];
  assign headerOk = (WriteData[HdrRsvdMsb:HdrRsvdLsb] == '0) &&
                    ({24'd0, hdrCol} < 32'(NumColumns));

  // Next-state logic. An accepted data word is parked in the pending stage;
  // the strobe and the visible FrameData both come out of that stage one
  // edge later, which keeps FrameData equal to the strobed word even when
  // words arrive back to back.
  always_comb begin
    state_d     = state_q;
    column_d    = column_q;
    frameCnt_d  = frameCnt_q;
    active_d    = active_q;
    done_d      = done_q;
    error_d     = error_q;
    pendEn_d    = 1'b0;
    pendCol_d   = pendCol_q;
    pendFrame_d = pendFrame_q;
    pendData_d  = pendData_q;

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (WriteData == SyncWord) begin
            state_d  = HEADER;
            active_d = 1'b1;
            done_d   = 1'b0;
            error_d  = 1'b0;
          end
        end
        HEADER: begin
          if (WriteData == DesyncWord) begin
            state_d  = IDLE;
            active_d = 1'b0;
            done_d   = 1'b1;
          end else if (headerOk) begin
            state_d    = DATA;
            column_d   = hdrCol;
            frameCnt_d = '0;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
            error_d  = 1'b1;
          end
        end
        DATA: begin
          pendEn_d    = 1'b1;
          pendCol_d   = column_q;
          pendFrame_d = frameCnt_q;
          pendData_d  = FrameBitsPerRow'(WriteData);
          if (frameCnt_q == LastFrame) begin
            frameCnt_d = '0;
            state_d    = HEADER;
          end else begin
            frameCnt_d = frameCnt_q + FrameCntW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers. ready_q comes up one edge after reset
  // release, giving the required dead cycle on WriteReady.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      column_q    <= '0;
      frameCnt_q  <= '0;
      ready_q     <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      pendEn_q    <= 1'b0;
      pendCol_q   <= '0;
      pendFrame_q <= '0;
      pendData_q  <= '0;
      frameData_q <= '0;
    end else begin
      state_q     <= state_d;
      column_q    <= column_d;
      frameCnt_q  <= frameCnt_d;
      ready_q     <= 1'b1;
      active_q    <= active_d;
      done_q      <= done_d;
      error_q     <= error_d;
      pendEn_q    <= pendEn_d;
      pendCol_q   <= pendCol_d;
      pendFrame_q <= pendFrame_d;
      pendData_q  <= pendData_d;
      if (pendEn_q) begin
        frameData_q <= pendData_q;
      end
    end
  end

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .NumColumns     (NumColumns),
    .FrameCntW      (FrameCntW)
  ) u_strobeDecoder (
    .clk_i   (CLK),
    .rst_i   (RST),
    .column_i(pendCol_q),
    .frame_i (pendFrame_q),
    .enable_i(pendEn_q),
    .strobe_o(FrameStrobe)
  );

  assign WriteReady   = ready_q;
  assign FrameData    = frameData_q;
  assign ConfigActive = active_q;
  assign ConfigDone   = done_q;
  assign ConfigError  = error_q;

endmodule
